// File: rtl/dcache_mem_tid_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_mem_tid_arb_pkg : shared memory-TID config and cache payload types  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dcache_mem_tid_arb_pkg;

  localparam int unsigned MemTidWidth    = 2;
  localparam int unsigned CacheAddrWidth = 64;
  localparam int unsigned CacheDataWidth = 64;

  typedef enum logic [1:0] {
    PORT_PTW   = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_STORE = 2'd2
  } dcache_port_e;

  typedef struct packed {
    logic [CacheAddrWidth-1:0] addr;
    logic [CacheDataWidth-1:0] wdata;
    logic                      we;
    logic [MemTidWidth-1:0]    tid;
  } dcache_mem_req_t;

  typedef struct packed {
    logic [MemTidWidth-1:0]    tid;
    logic [CacheDataWidth-1:0] rdata;
  } dcache_mem_rsp_t;

  // Circular successor of a port index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_mem_tid_arb_rr_arb_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb_tree : round-robin arbiter with lock-until-accept and gated enable   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arb_tree
  import dcache_mem_tid_arb_pkg::*;
#(
  parameter int unsigned NumIn = 3,
  parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] req_i,
  input  logic             en_i,
  input  logic             gnt_i,
  output logic             req_o,
  output logic [NumIn-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] r_ptr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;

  logic [IdxW-1:0] w_rr_idx;
  logic [IdxW-1:0] w_j;
  logic            w_found;
  logic            w_any;
  logic            w_hs;

  // First requester at or after the pointer, scanning circularly.
  always_comb begin
    w_found  = 1'b0;
    w_rr_idx = '0;
    w_j      = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      w_j = IdxW'((32'(r_ptr) + k) % NumIn);
      if (!w_found && req_i[w_j]) begin
        w_found  = 1'b1;
        w_rr_idx = w_j;
      end
    end
  end

  assign idx_o = r_lock ? r_lock_idx : w_rr_idx;
  assign w_any = r_lock ? req_i[r_lock_idx] : w_found;
  assign req_o = en_i & w_any;
  assign w_hs  = req_o & gnt_i;

  always_comb begin
    gnt_o = '0;
    if (w_hs) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      // With no free ID the request is masked and the lock must survive untouched.
      if (en_i) r_lock <= req_o & ~gnt_i;
      if (req_o && !r_lock) r_lock_idx <= w_rr_idx;
      if (w_hs) r_ptr <= IdxW'(rr_next(32'(idx_o), NumIn));
    end
  end

  a_req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_o && !gnt_i) |=> req_i[r_lock_idx]);

endmodule
`default_nettype wire

// File: rtl/dcache_mem_tid_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_mem_tid_arb : arbitrates cache ports onto memory, tags with free TID |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dcache_mem_tid_arb
  import dcache_mem_tid_arb_pkg::*;
#(
  parameter int unsigned NrPorts   = 3,
  parameter int unsigned TidWidth  = MemTidWidth,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrPorts-1:0]                 req_i,
  output logic [NrPorts-1:0]                 gnt_o,
  input  logic [NrPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NrPorts-1:0]                 we_i,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic [AddrWidth-1:0]               mem_addr_o,
  output logic [DataWidth-1:0]               mem_wdata_o,
  output logic                               mem_we_o,
  output logic [TidWidth-1:0]                mem_tid_o,
  input  logic                               mem_rvalid_i,
  input  logic [TidWidth-1:0]                mem_rtid_i,
  input  logic [DataWidth-1:0]               mem_rdata_i,
  output logic [NrPorts-1:0]                 rvalid_o,
  output logic [NrPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic [TidWidth:0]                  outstanding_o,
  output logic                               err_o
);

  localparam int unsigned NumTids = 1 << TidWidth;
  localparam int unsigned PortW   = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  logic [NumTids-1:0]                r_busy;
  logic [NumTids-1:0][PortW-1:0]     r_owner;
  logic [TidWidth:0]                 r_outstanding;
  logic                              r_err;
  logic [NrPorts-1:0]                r_rvalid;
  logic [NrPorts-1:0][DataWidth-1:0] r_rdata;

  logic                w_tid_avail;
  logic [TidWidth-1:0] w_free_tid;
  logic                w_arb_req;
  logic [NrPorts-1:0]  w_arb_gnt;
  logic [PortW-1:0]    w_sel;
  logic                w_hs;
  logic                w_rsp_busy;
  logic                w_rsp_ok;
  logic [PortW-1:0]    w_rsp_owner;

  // Lowest-numbered free ID; the downward scan lets the smallest index win.
  always_comb begin
    w_tid_avail = 1'b0;
    w_free_tid  = '0;
    for (int t = NumTids - 1; t >= 0; t--) begin
      if (!r_busy[t]) begin
        w_tid_avail = 1'b1;
        w_free_tid  = TidWidth'(t);
      end
    end
  end

  rr_arb_tree #(
    .NumIn (NrPorts),
    .IdxW  (PortW)
  ) u_rr_arb_tree (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .en_i   (w_tid_avail),
    .gnt_i  (mem_gnt_i),
    .req_o  (w_arb_req),
    .gnt_o  (w_arb_gnt),
    .idx_o  (w_sel)
  );

  // Reset gates the request side combinationally, not just via the flops.
  assign mem_req_o   = w_arb_req & rst_ni;
  assign gnt_o       = w_arb_gnt & {NrPorts{rst_ni}};
  assign mem_addr_o  = addr_i[w_sel];
  assign mem_wdata_o = wdata_i[w_sel];
  assign mem_we_o    = we_i[w_sel];
  assign mem_tid_o   = w_free_tid;

  assign w_hs        = mem_req_o & mem_gnt_i;
  assign w_rsp_busy  = r_busy[mem_rtid_i];
  assign w_rsp_ok    = mem_rvalid_i & w_rsp_busy;
  assign w_rsp_owner = r_owner[mem_rtid_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy        <= '0;
      r_owner       <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_rvalid      <= '0;
      r_rdata       <= '0;
    end else begin
      // Alloc picks a free ID and a valid response names a busy one, so they never collide.
      if (w_hs) begin
        r_busy[w_free_tid]  <= 1'b1;
        r_owner[w_free_tid] <= w_sel;
      end
      if (w_rsp_ok) r_busy[mem_rtid_i] <= 1'b0;

      r_rvalid <= '0;
      if (w_rsp_ok) begin
        r_rvalid[w_rsp_owner] <= 1'b1;
        r_rdata[w_rsp_owner]  <= mem_rdata_i;
      end

      if (mem_rvalid_i && !w_rsp_busy) r_err <= 1'b1;

      case ({w_hs, w_rsp_ok})
        2'b10:   r_outstanding <= r_outstanding + {{TidWidth{1'b0}}, 1'b1};
        2'b01:   r_outstanding <= r_outstanding - {{TidWidth{1'b0}}, 1'b1};
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_tid_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_mem_tid_arb : scoreboard bench with a transaction-level model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dcache_mem_tid_arb;

  localparam int NP = 3;
  localparam int NT = 4;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NP-1:0]        req_i = '0;
  logic [NP-1:0]        gnt_o;
  logic [NP-1:0][63:0]  addr_i = '0;
  logic [NP-1:0][63:0]  wdata_i = '0;
  logic [NP-1:0]        we_i = '0;
  logic                 mem_req_o;
  logic                 mem_gnt_i = 1'b0;
  logic [63:0]          mem_addr_o;
  logic [63:0]          mem_wdata_o;
  logic                 mem_we_o;
  logic [1:0]           mem_tid_o;
  logic                 mem_rvalid_i = 1'b0;
  logic [1:0]           mem_rtid_i = '0;
  logic [63:0]          mem_rdata_i = '0;
  logic [NP-1:0]        rvalid_o;
  logic [NP-1:0][63:0]  rdata_o;
  logic [2:0]           outstanding_o;
  logic                 err_o;

  always #5 clk = ~clk;

  dcache_mem_tid_arb #(.NrPorts(3), .TidWidth(2), .AddrWidth(64), .DataWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_tid_o(mem_tid_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rtid_i(mem_rtid_i), .mem_rdata_i(mem_rdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  typedef struct packed { logic req; logic [1:0] tid; logic [2:0] outst; logic err; logic [2:0] rv; } cyc_t;
  typedef struct packed { logic [1:0] port; logic [1:0] tid; logic [63:0] addr; logic [63:0] wdata; logic we; } gnt_t;
  typedef struct packed { logic [1:0] port; logic [63:0] data; } rsp_t;

  cyc_t cyc_q[$];
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  // Transaction-level reference state.
  bit          m_busy[NT];
  int          m_owner[NT];
  int          m_ptr;
  bit          m_locked;
  int          m_lock_port;
  bit          m_err;
  logic [2:0]  m_rv;
  logic [2:0]  held;
  logic [63:0] p_addr[NP];
  logic [63:0] p_wdata[NP];
  logic        p_we[NP];

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin m_busy[t] = 1'b0; m_owner[t] = 0; end
    m_ptr = 0; m_locked = 1'b0; m_lock_port = 0; m_err = 1'b0; m_rv = '0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int t = 0; t < NT; t++) c += int'(m_busy[t]);
    return c;
  endfunction

  function automatic int m_free_tid();
    for (int t = 0; t < NT; t++) if (!m_busy[t]) return t;
    return -1;
  endfunction

  function automatic int m_pick();
    if (m_locked) return m_lock_port;
    for (int k = 0; k < NP; k++) if (held[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
    return -1;
  endfunction

  task automatic drive_cycle(input logic [2:0] new_req, input logic g, input logic rv,
                             input logic [1:0] rtid, input logic [63:0] rd);
    int ft, sel, cnt;
    bit mreq;
    cyc_t c;
    gnt_t gr;
    rsp_t rr;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (new_req[p] && !held[p]) begin
        held[p]    = 1'b1;
        p_addr[p]  = {$urandom, $urandom};
        p_wdata[p] = {$urandom, $urandom};
        p_we[p]    = 1'($urandom % 2);
      end
      addr_i[p]  = p_addr[p];
      wdata_i[p] = p_wdata[p];
      we_i[p]    = p_we[p];
    end
    req_i = held; mem_gnt_i = g; mem_rvalid_i = rv; mem_rtid_i = rtid; mem_rdata_i = rd;

    ft = m_free_tid(); sel = m_pick(); cnt = m_count();
    mreq = (ft >= 0) && (sel >= 0);
    c.req = mreq; c.tid = (ft >= 0) ? 2'(ft) : 2'd0; c.outst = 3'(cnt); c.err = m_err; c.rv = m_rv;
    cyc_q.push_back(c);
    if (mreq && g) begin
      gr.port = 2'(sel); gr.tid = 2'(ft); gr.addr = p_addr[sel]; gr.wdata = p_wdata[sel]; gr.we = p_we[sel];
      gnt_q.push_back(gr);
    end

    m_rv = '0;
    if (rv) begin
      if (m_busy[rtid]) begin
        rr.port = 2'(m_owner[rtid]); rr.data = rd;
        rsp_q.push_back(rr);
        m_rv[m_owner[rtid]] = 1'b1;
        m_busy[rtid] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (mreq && g) begin
      m_busy[ft] = 1'b1; m_owner[ft] = sel; m_ptr = (sel + 1) % NP; m_locked = 1'b0; held[sel] = 1'b0;
    end else if (mreq) begin
      m_locked = 1'b1; m_lock_port = sel;
    end
    @(negedge clk); #1;
  endtask

  // Monitor: per-cycle expectations, plus grant/response events whenever the DUT shows them.
  cyc_t mc;
  gnt_t mg;
  rsp_t mr;
  always @(negedge clk) begin
    if (rst_ni && cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk("mem_req", 64'(mem_req_o), 64'(mc.req));
      if (mc.req) chk("mem_tid", 64'(mem_tid_o), 64'(mc.tid));
      chk("outstanding", 64'(outstanding_o), 64'(mc.outst));
      chk("err", 64'(err_o), 64'(mc.err));
      chk("rvalid_vec", 64'(rvalid_o), 64'(mc.rv));
      if (mem_req_o && mem_gnt_i) begin
        if (gnt_q.size() == 0) fail_now("unexpected_handshake");
        else begin
          mg = gnt_q.pop_front();
          chk("gnt_port", 64'(gnt_o), 64'(3'b001 << mg.port));
          chk("hs_tid", 64'(mem_tid_o), 64'(mg.tid));
          chk("hs_addr", mem_addr_o, mg.addr);
          chk("hs_wdata", mem_wdata_o, mg.wdata);
          chk("hs_we", 64'(mem_we_o), 64'(mg.we));
        end
      end else begin
        chk("gnt_idle", 64'(gnt_o), 64'd0);
      end
      for (int p = 0; p < NP; p++) begin
        if (rvalid_o[p]) begin
          if (rsp_q.size() == 0) fail_now("unexpected_rvalid");
          else begin
            mr = rsp_q.pop_front();
            chk("rsp_port", 64'(p), 64'(mr.port));
            chk("rsp_data", rdata_o[p], mr.data);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0]  exp_port [4];
  logic [63:0] d1, d2, d3, d4;
  int          bl[$];
  logic        rv;
  logic [1:0]  rt;

  initial begin
    exp_port[0] = 2'd0; exp_port[1] = 2'd1; exp_port[2] = 2'd2; exp_port[3] = 2'd0;
    held = '0;
    for (int p = 0; p < NP; p++) begin p_addr[p] = '0; p_wdata[p] = '0; p_we[p] = 1'b0; end
    model_reset();

    // Reset state, with requests already raised.
    req_i = 3'b111; mem_gnt_i = 1'b1;
    #12;
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    #10; req_i = '0; mem_gnt_i = 1'b0; rst_ni = 1'b1;

    // All three requesting, memory always accepting.
    for (int i = 0; i < 4; i++) begin
      drive_cycle(3'b111, 1'b1, 1'b0, 2'd0, 64'd0);
      chk("rr_gnt", 64'(gnt_o), 64'(3'b001 << exp_port[i]));
      chk("rr_tid", 64'(mem_tid_o), 64'(i));
    end

    // All IDs busy: no request even with a port pending; response on ID 2.
    d1 = {$urandom, $urandom};
    drive_cycle(3'b000, 1'b1, 1'b1, 2'd2, d1);
    chk("full_mem_req", 64'(mem_req_o), 64'd0);
    chk("full_outstanding", 64'(outstanding_o), 64'd4);
    chk("full_gnt", 64'(gnt_o), 64'd0);
    drive_cycle(3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
    chk("rsp2_rvalid", 64'(rvalid_o), 64'(3'b100));
    chk("rsp2_rdata", rdata_o[2], d1);
    chk("rsp2_tid", 64'(mem_tid_o), 64'd2);
    chk("rsp2_outstanding", 64'(outstanding_o), 64'd3);

    // Handshake on ID 2 while ID 0 returns: count holds, ID 0 not reused this cycle.
    d2 = {$urandom, $urandom};
    drive_cycle(3'b000, 1'b1, 1'b1, 2'd0, d2);
    chk("both_gnt", 64'(gnt_o), 64'(3'b010));
    chk("both_tid", 64'(mem_tid_o), 64'd2);
    d3 = {$urandom, $urandom};
    drive_cycle(3'b000, 1'b0, 1'b1, 2'd1, d3);
    chk("both_outstanding", 64'(outstanding_o), 64'd3);
    chk("both_rvalid", 64'(rvalid_o), 64'(3'b001));
    chk("reuse_tid", 64'(mem_tid_o), 64'd0);
    drive_cycle(3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
    chk("two_outstanding", 64'(outstanding_o), 64'd2);

    // Asynchronous reset with two IDs outstanding and a locked request.
    rst_ni = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req_o), 64'd0);
    chk("arst_gnt", 64'(gnt_o), 64'd0);
    chk("arst_outstanding", 64'(outstanding_o), 64'd0);
    chk("arst_rvalid", 64'(rvalid_o), 64'd0);
    chk("arst_rdata0", rdata_o[0], 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    model_reset();
    @(posedge clk); #2; rst_ni = 1'b1;

    // Late response to a dropped ID is stray.
    d4 = {$urandom, $urandom};
    drive_cycle(3'b000, 1'b1, 1'b1, 2'd3, d4);
    chk("post_rst_gnt", 64'(gnt_o), 64'(3'b100));
    chk("post_rst_tid", 64'(mem_tid_o), 64'd0);
    drive_cycle(3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
    chk("stray_err", 64'(err_o), 64'd1);
    chk("stray_rvalid", 64'(rvalid_o), 64'd0);
    chk("stray_outstanding", 64'(outstanding_o), 64'd1);
    drive_cycle(3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
    chk("stray_err_sticky", 64'(err_o), 64'd1);

    // Lock: port 2 stalls three cycles, then port 0 joins.
    for (int i = 0; i < 3; i++) begin
      drive_cycle((i == 0) ? 3'b100 : 3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
      chk("lock_addr", mem_addr_o, p_addr[2]);
      chk("lock_nognt", 64'(gnt_o), 64'd0);
    end
    drive_cycle(3'b001, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("lock_first_gnt", 64'(gnt_o), 64'(3'b100));
    chk("lock_first_addr", mem_addr_o, p_addr[2]);
    drive_cycle(3'b000, 1'b1, 1'b0, 2'd0, 64'd0);
    chk("lock_second_gnt", 64'(gnt_o), 64'(3'b001));

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bl.delete();
      for (int t = 0; t < NT; t++) if (m_busy[t]) bl.push_back(t);
      rv = 1'b0; rt = 2'd0;
      if (bl.size() > 0 && $urandom_range(0, 99) < 40) begin
        rv = 1'b1; rt = 2'(bl[$urandom_range(0, bl.size() - 1)]);
      end
      drive_cycle({($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                  ($urandom_range(0, 9) < 7), rv, rt, {$urandom, $urandom});
    end

    // Drain pending requests and outstanding IDs.
    for (int i = 0; i < 200; i++) begin
      if (m_count() == 0 && held == 3'b000) break;
      bl.delete();
      for (int t = 0; t < NT; t++) if (m_busy[t]) bl.push_back(t);
      rv = 1'b0; rt = 2'd0;
      if (bl.size() > 0) begin rv = 1'b1; rt = 2'(bl[0]); end
      drive_cycle(3'b000, 1'b1, rv, rt, {$urandom, $urandom});
    end
    drive_cycle(3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
    drive_cycle(3'b000, 1'b0, 1'b0, 2'd0, 64'd0);
    chk("drain_outstanding", 64'(outstanding_o), 64'd0);
    chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    chk("cyc_q_empty", 64'(cyc_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_mem_tid_arb.md
DCACHE_MEM_TID_ARB -- requirements
Module: dcache_mem_tid_arb

Interface
REQ-001 SHALL have parameter NrPorts, default 3, number of requesters (0=PTW, 1=load, 2=store).
REQ-002 SHALL have parameter TidWidth, default 2, memory transaction ID width (4 outstanding IDs).
REQ-003 SHALL have parameters AddrWidth, default 64, and DataWidth, default 64, request address and data widths.
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_i/gnt_o  in/out  NrPorts  per-port request valid and grant.
REQ-007 SHALL have ports addr_i/wdata_i/we_i  in  NrPorts x AddrWidth / NrPorts x DataWidth / NrPorts  per-port request payload.
REQ-008 SHALL have ports mem_req_o/mem_gnt_i  out/in  1  memory-side request valid and accept.
REQ-009 SHALL have ports mem_addr_o/mem_wdata_o/mem_we_o/mem_tid_o  out  AddrWidth/DataWidth/1/TidWidth  forwarded payload and allocated ID.
REQ-010 SHALL have ports mem_rvalid_i/mem_rtid_i/mem_rdata_i  in  1/TidWidth/DataWidth  memory response.
REQ-011 SHALL have ports rvalid_o/rdata_o  out  NrPorts / NrPorts x DataWidth  per-port response.
REQ-012 SHALL have ports outstanding_o  out  TidWidth+1  busy-ID count, and err_o  out  1  sticky stray-response flag.

Function
REQ-013 SHALL arbitrate round-robin among asserted req_i; pointer advances to one past the granted port only on a handshake (mem_req_o && mem_gnt_i).
REQ-014 SHALL hold the chosen port locked while mem_req_o is high and mem_gnt_i low; no re-arbitration, payload stable.
REQ-015 SHALL assert mem_req_o only if at least one req_i is high and at least one TID is free.
REQ-016 SHALL drive mem_tid_o with the lowest-numbered free TID, combinationally.
REQ-017 SHALL assert gnt_o[i] in the same cycle as the handshake, for the selected port only; zero-cycle grant latency.
REQ-018 SHALL, on handshake, mark the TID busy and record owner port index in a 2^TidWidth-entry table.
REQ-019 SHALL, on mem_rvalid_i with busy mem_rtid_i, assert rvalid_o[owner] one cycle later with registered rdata_o, and free the TID at that edge.
REQ-020 SHALL ignore mem_rvalid_i with a free mem_rtid_i: no rvalid_o, table unchanged, err_o set until reset.
REQ-021 SHALL make a TID freed in cycle N allocatable from cycle N+1 only; same-cycle alloc and free of different TIDs both take effect.
REQ-022 SHALL keep outstanding_o equal to busy-TID count: +1 on handshake, -1 on valid free, unchanged when both occur.
REQ-023 SHALL, when all TIDs busy, hold mem_req_o and all gnt_o low; lock and round-robin pointer unchanged.
REQ-024 SHALL treat a requester dropping req_i before grant as a protocol violation (simulation assertion), not a handled case.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously clear: all TIDs free, owner table 0, pointer 0, lock clear, err_o 0, outstanding_o 0, rvalid_o 0, rdata_o 0.
REQ-026 SHALL drop in-flight transactions on reset mid-operation; responses arriving after reset set err_o per REQ-020.
REQ-027 SHALL drive mem_req_o and gnt_o low combinationally while rst_ni low.

Structure
REQ-028 SHALL take TidWidth default from the shared config package memory TID width; request/response payload structs belong in the shared cache package.
REQ-029 SHALL instantiate the common round-robin arbiter tree (rr_arb_tree) as its single sub-module; TID pool and owner table are local.

Verification
REQ-030 SHALL cover: req_i=3'b111 held, mem_gnt_i=1 -> grants port 0,1,2,0 over 4 cycles, mem_tid_o 0,1,2,3, outstanding_o=4.
REQ-031 SHALL cover: 4 TIDs busy, req_i[1]=1 -> mem_req_o=0; response tid 2 -> next cycle rvalid_o[owner]=1, following cycle grant with mem_tid_o=2.
REQ-032 SHALL cover: req_i[2]=1, mem_gnt_i=0 for 3 cycles then req_i[0] rises -> port 2 stays selected, addr stable, granted first.
REQ-033 SHALL cover: mem_rvalid_i with free tid 3 -> no rvalid_o, err_o=1 and stays 1.
REQ-034 SHALL cover: handshake and valid response same cycle -> outstanding_o unchanged, freed TID not reissued that cycle.
REQ-035 SHALL cover: rst_ni low with 2 outstanding -> all outputs 0 asynchronously, outstanding_o=0, next grant uses TID 0.
